// File: rtl/i2c_reg_pkg.sv
// Shared constants, state encoding and address-window helper for the I2C
// register sequencer and its pointer.
package i2c_reg_pkg;

   // PID gain register map
   localparam logic [7:0]  K_P_ADDR      = 8'h20;
   localparam logic [7:0]  K_I_ADDR      = 8'h21;
   localparam logic [7:0]  K_D_ADDR      = 8'h22;
   localparam int unsigned NUM_GAIN_REGS = 3;
   localparam int unsigned GAIN_W        = 6;

   // Byte returned to the master when there is nothing valid to read
   localparam logic [7:0]  IDLE_BYTE     = 8'hFF;

   typedef enum logic [2:0] {
      StIdle,
      StPtr,
      StWrite,
      StRead,
      StFetch
   } seq_state_t;

   // True when addr lies in [base, base+num); done in 32 bits so the window end cannot wrap
   function automatic logic addr_in_window(input logic [7:0]  addr,
                                           input logic [7:0]  base,
                                           input int unsigned num);
      int unsigned a;
      int unsigned b;
      a = 32'(addr);
      b = 32'(base);
      return (a >= b) && (a < (b + num));
   endfunction

endpackage

// File: rtl/i2c_addr_ptr.sv
// Register pointer: loadable, increments with wrap inside the register window,
// and flags whether it currently addresses an implemented register.
module i2c_addr_ptr
   import i2c_reg_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = K_P_ADDR,
   parameter int unsigned NUM_REGS  = NUM_GAIN_REGS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       incr,
   output logic [7:0] ptr,
   output logic       in_range
);

   localparam logic [7:0] LAST_ADDR = 8'(32'(BASE_ADDR) + NUM_REGS - 32'd1);

   logic [7:0] ptr_q;
   logic [7:0] ptr_d;

   // Next pointer: load wins over increment; increment wraps at the last register
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = load_value;
      end else if (incr) begin
         ptr_d = (ptr_q == LAST_ADDR) ? BASE_ADDR : ptr_q + 8'd1;
      end
   end

   // Pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= BASE_ADDR;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr      = ptr_q;
   assign in_range = addr_in_window(ptr_q, BASE_ADDR, NUM_REGS);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Byte-level sequencer between the I2C slave byte engine and the PID gain
// register file: first written byte is the register pointer, later bytes are
// register writes; master reads fetch from the pointer. Pointer auto-increments.
module i2c_reg_sequencer
   import i2c_reg_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = K_P_ADDR,
   parameter int unsigned NUM_REGS  = NUM_GAIN_REGS,
   parameter int unsigned DATA_W    = GAIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic              stop,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ack,
   output logic              rx_ack_vld,
   input  logic              tx_req,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic [7:0]        reg_addr,
   output logic [DATA_W-1:0] update_value,
   output logic              read_or_write,
   input  logic [DATA_W-1:0] read_value
);

   seq_state_t state_q;
   seq_state_t state_d;

   logic              rx_ack_q,        rx_ack_d;
   logic              rx_ack_vld_q,    rx_ack_vld_d;
   logic [7:0]        tx_data_q,       tx_data_d;
   logic              tx_valid_q,      tx_valid_d;
   logic [7:0]        reg_addr_q,      reg_addr_d;
   logic [DATA_W-1:0] update_value_q,  update_value_d;
   logic              read_or_write_q, read_or_write_d;

   logic       ptr_load;
   logic       ptr_incr;
   logic [7:0] ptr;
   logic       ptr_in_range;

   i2c_addr_ptr #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_REGS  (NUM_REGS)
   ) u_addr_ptr (
      .clk        (clk),
      .rst        (rst),
      .load       (ptr_load),
      .load_value (rx_data),
      .incr       (ptr_incr),
      .ptr        (ptr),
      .in_range   (ptr_in_range)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: (repeated) START overrides STOP, which overrides in-state progress
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StIdle;
         StPtr:   if (rx_valid) state_d = StWrite;
         StWrite: state_d = StWrite;
         StRead:  if (tx_req) state_d = StFetch;
         StFetch: state_d = StRead;
         default: state_d = StIdle;
      endcase
      if (stop) begin
         state_d = StIdle;
      end
      if (start) begin
         state_d = rw ? StRead : StPtr;
      end
   end

   // Output next values; the byte in the current cycle is always handled by the current state
   always_comb begin
      rx_ack_d        = 1'b0;
      rx_ack_vld_d    = 1'b0;
      read_or_write_d = 1'b0;
      tx_valid_d      = 1'b0;
      tx_data_d       = tx_data_q;
      reg_addr_d      = reg_addr_q;
      update_value_d  = update_value_q;
      ptr_load        = 1'b0;
      ptr_incr        = 1'b0;

      if (rx_valid) begin
         unique case (state_q)
            StPtr: begin
               ptr_load     = 1'b1;
               rx_ack_vld_d = 1'b1;
               rx_ack_d     = addr_in_window(rx_data, BASE_ADDR, NUM_REGS);
            end
            StWrite: begin
               rx_ack_vld_d = 1'b1;
               if (ptr_in_range) begin
                  rx_ack_d        = 1'b1;
                  read_or_write_d = 1'b1;
                  reg_addr_d      = ptr;
                  update_value_d  = rx_data[DATA_W-1:0];
                  ptr_incr        = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (tx_req) begin
         if (state_q == StRead) begin
            reg_addr_d = ptr;
         end else if (state_q != StFetch) begin
            tx_data_d  = IDLE_BYTE;
            tx_valid_d = 1'b1;
         end
      end

      // read_value now reflects reg_addr set on the previous cycle
      if (state_q == StFetch) begin
         tx_valid_d = 1'b1;
         if (ptr_in_range) begin
            tx_data_d = 8'(read_value);
            ptr_incr  = 1'b1;
         end else begin
            tx_data_d = IDLE_BYTE;
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ack_q        <= 1'b0;
         rx_ack_vld_q    <= 1'b0;
         tx_data_q       <= 8'h00;
         tx_valid_q      <= 1'b0;
         reg_addr_q      <= BASE_ADDR;
         update_value_q  <= '0;
         read_or_write_q <= 1'b0;
      end else begin
         rx_ack_q        <= rx_ack_d;
         rx_ack_vld_q    <= rx_ack_vld_d;
         tx_data_q       <= tx_data_d;
         tx_valid_q      <= tx_valid_d;
         reg_addr_q      <= reg_addr_d;
         update_value_q  <= update_value_d;
         read_or_write_q <= read_or_write_d;
      end
   end

   assign rx_ack        = rx_ack_q;
   assign rx_ack_vld    = rx_ack_vld_q;
   assign tx_data       = tx_data_q;
   assign tx_valid      = tx_valid_q;
   assign reg_addr      = reg_addr_q;
   assign update_value  = update_value_q;
   assign read_or_write = read_or_write_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a small gain register file model.
module tb_i2c_reg_sequencer;
   import i2c_reg_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic       stop = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ack;
   logic       rx_ack_vld;
   logic       tx_req = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [7:0] reg_addr;
   logic [5:0] update_value;
   logic       read_or_write;
   logic [5:0] read_value;

   logic [5:0] gains [0:3];
   int         strobe_cnt = 0;
   int         ack_cnt = 0;
   int         nack_cnt = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] ofs;

   i2c_reg_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .rw            (rw),
      .stop          (stop),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ack        (rx_ack),
      .rx_ack_vld    (rx_ack_vld),
      .tx_req        (tx_req),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .reg_addr      (reg_addr),
      .update_value  (update_value),
      .read_or_write (read_or_write),
      .read_value    (read_value)
   );

   always #5 clk = ~clk;

   // Gain register file: combinational read, strobed write
   assign ofs        = reg_addr - K_P_ADDR;
   assign read_value = (reg_addr >= K_P_ADDR && reg_addr <= K_D_ADDR) ? gains[ofs[1:0]] : 6'h00;

   always @(posedge clk) begin
      if (read_or_write) begin
         strobe_cnt <= strobe_cnt + 1;
         if (reg_addr >= K_P_ADDR && reg_addr <= K_D_ADDR) gains[ofs[1:0]] <= update_value;
      end
      if (rx_ack_vld) begin
         if (rx_ack) ack_cnt <= ack_cnt + 1;
         else        nack_cnt <= nack_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic r);
      start = 1'b1;
      rw    = r;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   // Send one byte and check the registered response in the following cycle
   task automatic wr_byte(input string tag, input logic [7:0] b, input logic exp_ack,
                          input logic exp_wr, input logic [7:0] exp_addr,
                          input logic [5:0] exp_val);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk({tag, ".vld"}, 32'(rx_ack_vld), 32'd1);
      chk({tag, ".ack"}, 32'(rx_ack), 32'(exp_ack));
      chk({tag, ".strobe"}, 32'(read_or_write), 32'(exp_wr));
      if (exp_wr) begin
         chk({tag, ".addr"}, 32'(reg_addr), 32'(exp_addr));
         chk({tag, ".val"}, 32'(update_value), 32'(exp_val));
      end
   endtask

   // tx_req in READ: nothing after one cycle, data after two
   task automatic rd_byte(input string tag, input logic [7:0] exp);
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      chk({tag, ".early"}, 32'(tx_valid), 32'd0);
      @(negedge clk);
      chk({tag, ".valid"}, 32'(tx_valid), 32'd1);
      chk({tag, ".data"}, 32'(tx_data), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < 4; i++) gains[i] = 6'h00;
      @(negedge clk);
      @(negedge clk);
      chk("rst.reg_addr", 32'(reg_addr), 32'h20);
      chk("rst.update_value", 32'(update_value), 32'h0);
      chk("rst.strobe", 32'(read_or_write), 32'h0);
      chk("rst.ack", 32'(rx_ack), 32'h0);
      chk("rst.ack_vld", 32'(rx_ack_vld), 32'h0);
      chk("rst.tx_data", 32'(tx_data), 32'h0);
      chk("rst.tx_valid", 32'(tx_valid), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Pointer then three writes across the whole window
      do_start(1'b0);
      wr_byte("w1.ptr", 8'h20, 1'b1, 1'b0, 8'h00, 6'h00);
      wr_byte("w1.kp", 8'h08, 1'b1, 1'b1, 8'h20, 6'h08);
      wr_byte("w1.ki", 8'h10, 1'b1, 1'b1, 8'h21, 6'h10);
      wr_byte("w1.kd", 8'h20, 1'b1, 1'b1, 8'h22, 6'h20);
      do_stop();
      chk("w1.pulse_vld", 32'(rx_ack_vld), 32'd0);
      chk("w1.pulse_wr", 32'(read_or_write), 32'd0);
      chk("w1.gain_kp", 32'(gains[0]), 32'h08);
      chk("w1.gain_ki", 32'(gains[1]), 32'h10);
      chk("w1.gain_kd", 32'(gains[2]), 32'h20);
      chk("w1.strobes", 32'(strobe_cnt), 32'd3);
      chk("w1.acks", 32'(ack_cnt), 32'd4);

      // Pointer write, repeated START into read, three reads with wrap
      do_start(1'b0);
      wr_byte("r1.ptr", 8'h21, 1'b1, 1'b0, 8'h00, 6'h00);
      do_start(1'b1);
      rd_byte("r1.ki", 8'h10);
      rd_byte("r1.kd", 8'h20);
      rd_byte("r1.kp", 8'h08);
      do_stop();

      // Write wraps from K_d to K_p; pointer ends at K_i
      do_start(1'b0);
      wr_byte("w2.ptr", 8'h22, 1'b1, 1'b0, 8'h00, 6'h00);
      wr_byte("w2.kd", 8'h05, 1'b1, 1'b1, 8'h22, 6'h05);
      wr_byte("w2.kp", 8'h07, 1'b1, 1'b1, 8'h20, 6'h07);
      do_stop();
      chk("w2.gain_kd", 32'(gains[2]), 32'h05);
      chk("w2.gain_kp", 32'(gains[0]), 32'h07);
      do_start(1'b1);
      rd_byte("w2.ptr_ki", 8'h10);
      do_stop();

      // Out-of-range pointer: NACKs, no strobes; tx_req outside READ gives idle byte
      do_start(1'b0);
      wr_byte("w3.ptr", 8'h30, 1'b0, 1'b0, 8'h00, 6'h00);
      wr_byte("w3.data", 8'h11, 1'b0, 1'b0, 8'h00, 6'h00);
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      chk("w3.tx_valid", 32'(tx_valid), 32'd1);
      chk("w3.tx_data", 32'(tx_data), 32'hFF);
      do_stop();
      chk("w3.strobes", 32'(strobe_cnt), 32'd5);
      chk("w3.nacks", 32'(nack_cnt), 32'd2);
      chk("w3.gain_kp", 32'(gains[0]), 32'h07);
      chk("w3.gain_ki", 32'(gains[1]), 32'h10);
      chk("w3.gain_kd", 32'(gains[2]), 32'h05);

      // Reset right after a write byte is accepted: strobe never reaches an edge
      do_start(1'b0);
      wr_byte("rs.ptr", 8'h21, 1'b1, 1'b0, 8'h00, 6'h00);
      rx_data  = 8'h3F;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      chk("rs.strobe", 32'(read_or_write), 32'd0);
      chk("rs.ack_vld", 32'(rx_ack_vld), 32'd0);
      chk("rs.reg_addr", 32'(reg_addr), 32'h20);
      chk("rs.update_value", 32'(update_value), 32'h0);
      chk("rs.tx_data", 32'(tx_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rs.gain_ki", 32'(gains[1]), 32'h10);
      chk("rs.strobes", 32'(strobe_cnt), 32'd5);
      do_start(1'b1);
      rd_byte("rs.ptr_kp", 8'h07);
      do_stop();

      // Last byte with STOP in the same cycle; upper data bits are dropped
      do_start(1'b0);
      wr_byte("sp.ptr", 8'h22, 1'b1, 1'b0, 8'h00, 6'h00);
      rx_data  = 8'hEA;
      rx_valid = 1'b1;
      stop     = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      stop     = 1'b0;
      chk("sp.strobe", 32'(read_or_write), 32'd1);
      chk("sp.addr", 32'(reg_addr), 32'h22);
      chk("sp.val", 32'(update_value), 32'h2A);
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      chk("sp.tx_valid", 32'(tx_valid), 32'd1);
      chk("sp.tx_data", 32'(tx_data), 32'hFF);
      chk("sp.gain_kd", 32'(gains[2]), 32'h2A);
      // Byte in IDLE gets no response at all
      rx_data  = 8'h01;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("sp.idle_vld", 32'(rx_ack_vld), 32'd0);
      chk("sp.idle_wr", 32'(read_or_write), 32'd0);
      chk("sp.ki_reg", 32'(gains[K_I_ADDR - K_P_ADDR]), 32'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
